// File: rtl/irq_prio_ctrl.sv
// rtl/irq_prio_ctrl.sv - edge-latched, masked interrupt arbiter with a valid/ready grant port
// Fixed-priority (lowest index) or round-robin selection; one grant in flight at a time.
module irq_prio_ctrl #(
  parameter int N_CH = 9,
  parameter int ID_W = $clog2(N_CH),
  parameter int RR   = 0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [N_CH-1:0] irq_req_i,
  input  logic [N_CH-1:0] irq_mask_i,
  input  logic            irq_ready_i,
  input  logic [N_CH-1:0] clr_ovr_i,
  output logic            irq_valid_o,
  output logic [ID_W-1:0] irq_id_o,
  output logic [N_CH-1:0] pending_o,
  output logic [N_CH-1:0] overrun_o
);

  localparam int IW1 = ID_W + 1;

  typedef enum logic {S_IDLE, S_PRESENT} state_e;

  state_e          state_q;
  logic [N_CH-1:0] req_q, pending_q, pending_d, overrun_q, overrun_d;
  logic [N_CH-1:0] edge_v, eligible, grant_clr;
  logic [ID_W-1:0] id_q, last_q, win_id;
  logic            win_found, accept;
  logic [IW1-1:0]  idx;

  assign edge_v    = irq_req_i & ~req_q;
  assign accept    = (state_q == S_PRESENT) & irq_ready_i;
  assign grant_clr = accept ? (N_CH'(1) << id_q) : '0;
  // A new edge in the accept cycle re-arms the channel and is not an overrun.
  assign pending_d = (pending_q & ~grant_clr) | edge_v;
  assign overrun_d = (overrun_q & ~clr_ovr_i) | (edge_v & pending_q & ~grant_clr);
  assign eligible  = pending_q & irq_mask_i;

  // idx carries one spare bit so last+1+k can be wrapped with a single subtract.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = '0;
    for (int k = 0; k < N_CH; k++) begin
      idx = (RR != 0) ? ({1'b0, last_q} + IW1'(k + 1)) : IW1'(k);
      if (idx >= IW1'(N_CH)) idx = idx - IW1'(N_CH);
      if (!win_found && eligible[idx[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_id    = idx[ID_W-1:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      req_q     <= '0;
      pending_q <= '0;
      overrun_q <= '0;
      id_q      <= '0;
      last_q    <= ID_W'(N_CH - 1);
    end else begin
      req_q     <= irq_req_i;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      case (state_q)
        S_IDLE: begin
          if (win_found) begin
            id_q    <= win_id;
            state_q <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (irq_ready_i) begin
            last_q  <= id_q;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign irq_valid_o = (state_q == S_PRESENT);
  assign irq_id_o    = id_q;
  assign pending_o   = pending_q;
  assign overrun_o   = overrun_q;

endmodule
